// File: rtl/denise_scandoubler_linebuf_pkg.sv
// rtl/denise_scandoubler_linebuf_pkg.sv - shared widths, defaults and read-side state type
package denise_scandoubler_linebuf_pkg;

  localparam int RGB_W      = 24;
  localparam int PIX_W      = RGB_W + 1;
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_HS_LEN = 32;

  typedef enum logic [1:0] {
    RD_BLANK = 2'd0,
    RD_HALF0 = 2'd1,
    RD_HALF1 = 2'd2
  } rd_state_t;

endpackage

// File: rtl/denise_linebuf_ram.sv
// rtl/denise_linebuf_ram.sv - simple dual-port line RAM with registered read
module denise_linebuf_ram #(
  parameter int AW = 10,
  parameter int DW = 25
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Write-first on address collision so a one-pixel line closed by a
  // coincident strobe still reads back its only pixel.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/denise_scandoubler_linebuf.sv
// rtl/denise_scandoubler_linebuf.sv - ping-pong line buffer replaying each line twice
module denise_scandoubler_linebuf
  import denise_scandoubler_linebuf_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int HS_LEN = DEF_HS_LEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk7_en,
  input  logic [RGB_W-1:0] rgb_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             blank_in,
  input  logic             dbl_en,
  output logic             pix_en,
  output logic [RGB_W-1:0] rgb_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             blank_out,
  output logic             ovf
);

  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  logic [1:0]        phase;
  logic              hs_q;
  logic              mode;
  logic [ADDR_W-1:0] wr_ptr;
  logic              wr_bank;
  logic [ADDR_W-1:0] line_len;
  logic              vs_lat;

  rd_state_t         rd_state, rd_state_n;
  logic [ADDR_W-1:0] rd_ptr, rd_ptr_n;
  logic              rd_bank, rd_bank_n;

  logic              s;
  logic              hs_rise;
  logic              we;
  logic              rd_last;
  logic              hs_act;
  logic [ADDR_W-1:0] len_at_edge;
  logic [PIX_W-1:0]  rd_data;

  assign s           = clk7_en | (phase == 2'd2);
  assign hs_rise     = hsync_in & ~hs_q;
  assign we          = clk7_en && (wr_ptr != PTR_MAX);
  // A pixel landing on the hsync edge still belongs to the line being closed.
  assign len_at_edge = wr_ptr + ADDR_W'(we);
  assign rd_last     = (rd_ptr == line_len - ADDR_W'(1));
  assign hs_act      = (32'(rd_ptr) < HS_LEN);

  denise_linebuf_ram #(
    .AW (ADDR_W + 1),
    .DW (PIX_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr ({wr_bank, wr_ptr}),
    .wdata ({rgb_in, blank_in}),
    .raddr ({rd_bank_n, rd_ptr_n}),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state <= RD_BLANK;
      rd_ptr   <= '0;
      rd_bank  <= 1'b0;
    end else begin
      rd_state <= rd_state_n;
      rd_ptr   <= rd_ptr_n;
      rd_bank  <= rd_bank_n;
    end
  end

  // Read address is taken from the next state so the RAM output always
  // matches the current rd_ptr, even on back-to-back strobes.
  always_comb begin
    rd_state_n = rd_state;
    rd_ptr_n   = rd_ptr;
    rd_bank_n  = rd_bank;
    if (hs_rise) begin
      rd_ptr_n   = '0;
      rd_bank_n  = wr_bank;
      rd_state_n = (len_at_edge != '0) ? RD_HALF0 : RD_BLANK;
    end else if (s) begin
      case (rd_state)
        RD_HALF0: begin
          if (rd_last) begin
            rd_ptr_n   = '0;
            rd_state_n = RD_HALF1;
          end else begin
            rd_ptr_n = rd_ptr + ADDR_W'(1);
          end
        end
        RD_HALF1: begin
          if (rd_last) begin
            rd_ptr_n   = '0;
            rd_state_n = RD_BLANK;
          end else begin
            rd_ptr_n = rd_ptr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase     <= 2'd0;
      hs_q      <= 1'b0;
      mode      <= dbl_en;
      wr_ptr    <= '0;
      wr_bank   <= 1'b0;
      line_len  <= '0;
      vs_lat    <= 1'b0;
      ovf       <= 1'b0;
      pix_en    <= 1'b0;
      rgb_out   <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      blank_out <= 1'b0;
    end else begin
      phase <= clk7_en ? 2'd1 : phase + 2'd1;
      hs_q  <= hsync_in;

      if (clk7_en) begin
        if (wr_ptr == PTR_MAX) ovf <= 1'b1;
        else                   wr_ptr <= wr_ptr + ADDR_W'(1);
      end

      if (hs_rise) begin
        line_len <= len_at_edge;
        wr_ptr   <= '0;
        wr_bank  <= ~wr_bank;
        mode     <= dbl_en;
        vs_lat   <= vsync_in;
      end else if (s && (rd_state == RD_HALF0) && rd_last) begin
        vs_lat <= vsync_in;
      end

      pix_en <= mode ? s : clk7_en;

      if (mode) begin
        if (s) begin
          vsync_out <= vs_lat;
          if (rd_state == RD_BLANK) begin
            rgb_out   <= '0;
            blank_out <= 1'b1;
            hsync_out <= 1'b0;
          end else begin
            rgb_out   <= rd_data[PIX_W-1:1];
            blank_out <= rd_data[0];
            hsync_out <= hs_act;
          end
        end
      end else if (clk7_en) begin
        rgb_out   <= rgb_in;
        blank_out <= blank_in;
        hsync_out <= hsync_in;
        vsync_out <= vsync_in;
      end
    end
  end

endmodule
